// File: rtl/fwd_sel_ctrl_if.sv
// ID-stage request bundle and registered forwarding-select response for the
// EX operand mux. The pipeline front end drives the ID-side signals
// (master); fwd_sel_ctrl answers with the select and hazard outputs (slave).
interface fwd_sel_ctrl_if #(
  parameter int REGW = 5
);
  logic            id_valid;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rd;
  logic            id_wr;
  logic            id_load;
  logic            stall;
  logic            flush;
  logic [1:0]      select;
  logic [1:0]      invSelect;
  logic            load_use;

  modport master (
    output id_valid, id_rs, id_rd, id_wr, id_load, stall, flush,
    input  select, invSelect, load_use
  );

  modport slave (
    input  id_valid, id_rs, id_rd, id_wr, id_load, stall, flush,
    output select, invSelect, load_use
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// Operand forwarding control for one EX source operand.
// A three-deep tag pipeline (EX, MEM, WB) shadows the destination registers
// of in-flight instructions. For the instruction currently in ID, the
// youngest matching producer selects the forwarding source. The select is
// registered so that it lines up with that instruction once it reaches EX.
// A load sitting in EX whose result the ID instruction needs raises
// load_use; the instruction then enters EX as a bubble and re-evaluates
// next cycle, by which time the load is in MEM and forwards normally.
module fwd_sel_ctrl #(
  parameter int REGW     = 5,
  parameter int ZERO_REG = 31
) (
  input logic         clk,
  input logic         reset_n,
  fwd_sel_ctrl_if.slave bus
);

  localparam logic [REGW-1:0] ZERO_IDX = REGW'(ZERO_REG);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            wr;
    logic            load;
  } tag_t;

  tag_t       ex_q, mem_q, wb_q;
  tag_t       ex_d;
  logic [1:0] sel_q, inv_q, sel_d;
  logic       ex_hit, mem_hit, wb_hit;
  logic       issue;
  logic       load_use;

  // A stage is a forwarding source only for a real writer of a non-zero register.
  function automatic logic produces(input tag_t t, input logic [REGW-1:0] r);
    return t.valid && t.wr && (t.rd == r) && (r != ZERO_IDX);
  endfunction

  // Match the ID source against pre-edge tags, detect load-use, pick the next select.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can leave
    // a stale value behind and infer a latch.
    ex_hit   = produces(ex_q,  bus.id_rs);
    mem_hit  = produces(mem_q, bus.id_rs);
    wb_hit   = produces(wb_q,  bus.id_rs);
    load_use = bus.id_valid && !bus.flush && ex_hit && ex_q.load;
    issue    = bus.id_valid && !bus.flush && !load_use;
    sel_d    = SEL_RF;
    if (issue) begin
      if (ex_hit)       sel_d = SEL_EX;
      else if (mem_hit) sel_d = SEL_MEM;
      else if (wb_hit)  sel_d = SEL_WB;
    end
    ex_d.valid = issue;
    ex_d.rd    = bus.id_rd;
    ex_d.wr    = bus.id_wr;
    ex_d.load  = bus.id_load;
  end

  // Advance the tag pipeline and register select/invSelect; a stall freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every stage
    // samples its neighbour's pre-edge value, giving a true shift.
    if (!reset_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      sel_q <= SEL_RF;
      inv_q <= ~SEL_RF;
    end else if (!bus.stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      sel_q <= sel_d;
      inv_q <= ~sel_d;
    end
  end

  assign bus.select    = sel_q;
  assign bus.invSelect = inv_q;
  assign bus.load_use  = load_use;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl. Each step drives one ID instruction on a
// falling edge, checks the combinational load_use, and queues the select it
// expects after the next rising edge; the queue is popped and compared
// just after that edge.
module tb_fwd_sel_ctrl;

  localparam int REGW = 5;

  typedef struct {
    string      tag;
    logic [1:0] sel;
  } exp_t;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  fwd_sel_ctrl_if #(.REGW(REGW)) bus();

  fwd_sel_ctrl #(.REGW(REGW), .ZERO_REG(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input bit v, input int rs, input int rd,
                      input bit wr, input bit ld, input bit st, input bit fl,
                      input logic [1:0] exp_sel, input logic exp_lu);
    exp_t e;
    @(negedge clk);
    bus.id_valid = v;
    bus.id_rs    = REGW'(rs);
    bus.id_rd    = REGW'(rd);
    bus.id_wr    = wr;
    bus.id_load  = ld;
    bus.stall    = st;
    bus.flush    = fl;
    #1;
    check({tag, "_lu"}, {1'b0, bus.load_use}, {1'b0, exp_lu});
    sb.push_back('{tag, exp_sel});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 2'd1, 2'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_sel"}, bus.select, e.sel);
      check({e.tag, "_inv"}, bus.invSelect, ~e.sel);
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 0, 0, 0, 0, 0, 2'd0, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_rs    = '0;
    bus.id_rd    = '0;
    bus.id_wr    = 1'b0;
    bus.id_load  = 1'b0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;

    // Reset asserted before the first clock edge.
    #1 reset_n = 1'b0;
    #2;
    check("rst_sel", bus.select, 2'd0);
    check("rst_inv", bus.invSelect, 2'd3);
    check("rst_lu", {1'b0, bus.load_use}, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ALU chain: writer of x3, then reader of x3.
    step("alu_w3", 1, 0, 3, 1, 0, 0, 0, 2'd0, 1'b0);
    step("alu_r3", 1, 3, 10, 1, 0, 0, 0, 2'd1, 1'b0);

    // Distance 1, 2 and 3.
    bubbles(3);
    step("d1_w5", 1, 0, 5, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d1_u", 1, 1, 12, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d1_r5", 1, 5, 13, 1, 0, 0, 0, 2'd2, 1'b0);
    bubbles(3);
    step("d2_w5", 1, 0, 5, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d2_u1", 1, 1, 12, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d2_u2", 1, 1, 13, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d2_r5", 1, 5, 0, 0, 0, 0, 0, 2'd3, 1'b0);
    bubbles(3);
    step("d3_w5", 1, 0, 5, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d3_u1", 1, 1, 12, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d3_u2", 1, 1, 13, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d3_u3", 1, 1, 14, 1, 0, 0, 0, 2'd0, 1'b0);
    step("d3_r5", 1, 5, 0, 0, 0, 0, 0, 2'd0, 1'b0);

    // Priority: writers of x7 in WB, MEM and EX; then without the EX writer.
    bubbles(3);
    step("pr_w7a", 1, 0, 7, 1, 0, 0, 0, 2'd0, 1'b0);
    step("pr_w7b", 1, 0, 7, 1, 0, 0, 0, 2'd0, 1'b0);
    step("pr_w7c", 1, 0, 7, 1, 0, 0, 0, 2'd0, 1'b0);
    step("pr_r7_ex", 1, 7, 0, 0, 0, 0, 0, 2'd1, 1'b0);
    step("pr_w7d", 1, 0, 7, 1, 0, 0, 0, 2'd0, 1'b0);
    step("pr_w7e", 1, 0, 7, 1, 0, 0, 0, 2'd0, 1'b0);
    step("pr_u12", 1, 0, 12, 1, 0, 0, 0, 2'd0, 1'b0);
    step("pr_r7_mem", 1, 7, 0, 0, 0, 0, 0, 2'd2, 1'b0);

    // Load-use: hazard, bubble, re-evaluation with the load in MEM.
    bubbles(3);
    step("lu_ld9", 1, 0, 9, 1, 1, 0, 0, 2'd0, 1'b0);
    step("lu_hazard", 1, 9, 15, 1, 0, 0, 0, 2'd0, 1'b1);
    step("lu_reeval", 1, 9, 16, 1, 0, 0, 0, 2'd2, 1'b0);
    step("lu_bubble", 1, 15, 0, 0, 0, 0, 0, 2'd0, 1'b0);

    // Zero register is never forwarded, not even from a load.
    bubbles(3);
    step("z_w31", 1, 0, 31, 1, 0, 0, 0, 2'd0, 1'b0);
    step("z_r31", 1, 31, 0, 0, 0, 0, 0, 2'd0, 1'b0);
    step("z_ld31", 1, 0, 31, 1, 1, 0, 0, 2'd0, 1'b0);
    step("z_r31_ld", 1, 31, 0, 0, 0, 0, 0, 2'd0, 1'b0);

    // Flush: flushed reader gets select 0 and leaves a bubble in EX.
    step("fl_w3", 1, 0, 3, 1, 0, 0, 0, 2'd0, 1'b0);
    step("fl_r3", 1, 3, 22, 1, 0, 0, 1, 2'd0, 1'b0);
    step("fl_r22", 1, 22, 0, 0, 0, 0, 0, 2'd0, 1'b0);

    // Stall (with flush held too): select, invSelect and tags frozen.
    bubbles(3);
    step("st_w4", 1, 0, 4, 1, 0, 0, 0, 2'd0, 1'b0);
    step("st_r4", 1, 4, 25, 1, 0, 0, 0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) step("st_hold", 1, 25, 26, 1, 0, 1, 1, 2'd1, 1'b0);
    step("st_release", 1, 4, 27, 1, 0, 0, 0, 2'd2, 1'b0);

    // Mid-stream reset pulse between clock edges.
    bubbles(3);
    step("mr_w6", 1, 0, 6, 1, 0, 0, 0, 2'd0, 1'b0);
    step("mr_r6", 1, 6, 0, 0, 0, 0, 0, 2'd1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("mr_rst_sel", bus.select, 2'd0);
    check("mr_rst_inv", bus.invSelect, 2'd3);
    @(negedge clk);
    reset_n = 1'b1;
    step("mr_after", 1, 6, 0, 0, 0, 0, 0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
FWD_SEL_CTRL -- requirements
Module: fwd_sel_ctrl

Interface
REQ-001 Parameter REGW, default 5, register-index width.
REQ-002 Parameter ZERO_REG, default 31, hard-zero register index; never forwarded.
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port id_valid, input, 1, the instruction in ID is real (not a bubble).
REQ-006 Port id_rs, input, REGW, source register in ID whose operand the 4:1 operand mux selects.
REQ-007 Port id_rd, input, REGW, destination register of the ID instruction.
REQ-008 Port id_wr, input, 1, the ID instruction writes id_rd.
REQ-009 Port id_load, input, 1, the ID instruction is a load; its result is first available in MEM/WB.
REQ-010 Port stall, input, 1, global pipeline freeze.
REQ-011 Port flush, input, 1, kill the instruction advancing from ID to EX.
REQ-012 Port select, output, 2, registered mux select for the EX operand: 0 regfile, 1 EX/MEM result, 2 MEM/WB result, 3 WB writeback value.
REQ-013 Port invSelect, output, 2, bitwise complement of select, registered alongside it.
REQ-014 Port load_use, output, 1, combinational hazard request to stall ID.

Function
REQ-015 The block SHALL hold a 3-entry tag pipeline (EX, MEM, WB), each entry {valid, rd, wr, load}.
REQ-016 On each edge with stall=0, MEM SHALL copy to WB and EX SHALL copy to MEM.
REQ-017 With stall=0, the EX entry SHALL load {id_valid & ~flush & ~load_use, id_rd, id_wr, id_load}; the next EX entry is a bubble when the current ID instruction is flushed or hazarded.
REQ-018 A stage "produces r" when valid=1, wr=1, rd=r and r != ZERO_REG.
REQ-019 With stall=0, select SHALL load the value computed against pre-edge tags, highest priority first:
- 1 if EX produces id_rs;
- else 2 if MEM produces id_rs;
- else 3 if WB produces id_rs;
- else 0.
REQ-020 select SHALL load 0 when id_valid=0, flush=1 or load_use=1, regardless of matches.
REQ-021 invSelect SHALL equal ~select at every cycle, including during reset.
REQ-022 load_use SHALL be 1 iff id_valid=1, flush=0, the EX entry produces id_rs and the EX entry has load=1.
REQ-023 On an edge with stall=1, all tag entries, select and invSelect SHALL hold their values.
REQ-024 stall=1 with flush=1 SHALL hold all state; the flush takes effect on the first edge with stall=0 only if flush is still asserted then.
REQ-025 A load in MEM matching id_rs SHALL forward with select=2 and no hazard.
REQ-026 id_rs=ZERO_REG SHALL always yield select=0 and load_use=0.
REQ-027 Latency: select is valid in the cycle after the instruction leaves ID, aligned with that instruction in EX.

Reset
REQ-028 While reset_n=0, all tag valid bits SHALL be 0, select SHALL be 2'b00, invSelect SHALL be 2'b11 and load_use SHALL be 0, independent of clk.
REQ-029 Reset deassertion mid-stream SHALL produce no forwarding until new producers enter EX; the first edge after release behaves as a normal edge.

Verification
REQ-030 ALU chain: an instruction writing x3, then the next instruction reading x3 -> select=1 and invSelect=2 in the consumer's EX cycle.
REQ-031 Distance tests: producer of x5 followed by 1 or 2 unrelated instructions, then a reader of x5 -> select=2 or 3 respectively; with 3 unrelated instructions in between -> select=0.
REQ-032 Priority: writers of x7 in WB, MEM and EX at the same time, reader of x7 in ID -> select=1; remove the EX writer -> select=2.
REQ-033 Load-use: a load to x9 in EX with a reader of x9 in ID -> load_use=1 and the next EX entry is a bubble; after one stall cycle the reader re-evaluates with the load in MEM -> select=2, load_use=0.
REQ-034 Zero register and flush: a writer of x31 then a reader of x31 -> select=0; a reader of x3 with flush=1 -> select=0 and the EX entry invalid next cycle.
REQ-035 Stall and reset: stall=1 for 3 cycles -> select, invSelect and tags are constant; pulse reset_n low between clock edges -> select=0 and invSelect=3 immediately, without waiting for clk.
